// File: rtl/mips_pkg.sv
// Shared store-path definitions: access size encodings, the store-merge state type
// and the alignment rule used when STORE_MERGE_ALIGN_CHK_EN is defined.
package mips_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WAIT  = 3'd2,
        MERGE = 3'd3,
        DONE  = 3'd4
    } store_merge_state_t;

    // Reserved size has no legal alignment; bytes are always aligned.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] byteOff);
        case (size)
            SZ_WORD: return byteOff != 2'b00;
            SZ_HALF: return byteOff[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational lane insert: drops the low byte/halfword of newData into the
// addressed little-endian lane of oldWord. Word/reserved sizes return newData.
module lane_merge
    import mips_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [31:0] newData,
    input  logic [1:0]  size,
    input  logic [1:0]  byteOff,
    output logic [31:0] merged
);

    always_comb begin
        merged = oldWord;
        case (size)
            SZ_BYTE: merged[{byteOff, 3'b000} +: 8]   = newData[7:0];
            SZ_HALF: merged[{byteOff[1], 4'b0000} +: 16] = newData[15:0];
            default: merged = newData;
        endcase
    end

endmodule

// File: rtl/store_merge.sv
// Merged store-word generator: word stores pass B through, sub-word stores do a
// read-modify-write of the memory word. STORE_MERGE_ALIGN_CHK_EN enables the err pulse.
module store_merge
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] b_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              busy,
    output logic [DATA_W-1:0] wc_data,
    output logic              wc_valid,
    output logic              err
);

    // Handshake: start is sampled only while busy==0 (IDLE or DONE) and is dropped
    // otherwise; each accepted request ends in exactly one DONE cycle carrying a
    // wc_valid pulse (or an err pulse), and busy is low there so a new start may follow.

    store_merge_state_t state;
    logic [1:0]         sizeQ;
    logic [1:0]         offQ;
    logic [DATA_W-1:0]  bQ;
    logic [DATA_W-1:0]  mergedWord;
    logic [1:0]         waitCnt;
    logic               misaligned;
    logic               isSubWord;

    assign isSubWord = (size == SZ_BYTE) || (size == SZ_HALF);

`ifdef STORE_MERGE_ALIGN_CHK_EN
    logic errQ;
    assign misaligned = isMisaligned(size, byte_off);
    assign err        = errQ;
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    lane_merge uLaneMerge (
        .oldWord (mem_rdata),
        .newData (bQ),
        .size    (sizeQ),
        .byteOff (offQ),
        .merged  (mergedWord)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            wc_valid <= 1'b0;
            wc_data  <= '0;
            sizeQ    <= SZ_WORD;
            offQ     <= 2'b00;
            bQ       <= '0;
            waitCnt  <= 2'd0;
`ifdef STORE_MERGE_ALIGN_CHK_EN
            errQ     <= 1'b0;
`endif
        end else begin
            mem_rd   <= 1'b0;
            wc_valid <= 1'b0;
`ifdef STORE_MERGE_ALIGN_CHK_EN
            errQ     <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    busy <= 1'b0;
                    if (start) begin
                        sizeQ <= size;
                        offQ  <= byte_off;
                        bQ    <= b_data;
                        if (misaligned) begin
                            state <= DONE;
`ifdef STORE_MERGE_ALIGN_CHK_EN
                            errQ  <= 1'b1;
`endif
                        end else if (isSubWord) begin
                            state  <= RD;
                            mem_rd <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            state    <= DONE;
                            wc_data  <= b_data;
                            wc_valid <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RD: begin
                    if (MEM_LAT == 1) begin
                        state <= MERGE;
                    end else begin
                        state   <= WAIT;
                        waitCnt <= 2'(MEM_LAT - 2);
                    end
                end
                // Holds MEM_LAT-1 cycles so MERGE lands on the cycle read data is valid.
                WAIT: begin
                    if (waitCnt == 2'd0) state <= MERGE;
                    else                 waitCnt <= waitCnt - 2'd1;
                end
                MERGE: begin
                    wc_data  <= mergedWord;
                    wc_valid <= 1'b1;
                    busy     <= 1'b0;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge.sv
// Randomized scoreboard bench for store_merge: three instances (MEM_LAT 1, 3, 4)
// driven independently, checked every cycle against a behavioural store model.
module tb_store_merge;
    import mips_pkg::*;

    localparam int N = 3;

`ifdef STORE_MERGE_ALIGN_CHK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    function automatic int latOf(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    typedef struct {
        logic [31:0] data;
        int unsigned issued;
        int unsigned due;
        bit          isSub;
        bit          isErr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN[N];
    logic        start[N];
    logic [1:0]  size[N];
    logic [1:0]  byteOff[N];
    logic [31:0] bData[N];
    logic [31:0] memRdata[N];
    logic [31:0] memWord[N];
    logic [31:0] junk[N];
    logic        memRd[N];
    logic        busy[N];
    logic [31:0] wcData[N];
    logic        wcValid[N];
    logic        err[N];
    logic [3:0]  rdPipe[N] = '{default: 4'b0};

    exp_t        exp_q[N][$];
    int unsigned rdQ[N][$];
    logic [31:0] expWc[N] = '{default: 32'h0};
    bit          rstSeen[N];
    int unsigned nextFree[N];
    int unsigned lastIssue[N];
    int unsigned cyc = 0;
    int          nVec = 0;
    int          nBad = 0;

    // ---------------- clock / reset / DUTs ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            store_merge #(.DATA_W(32), .MEM_LAT(latOf(g))) dut (
                .clk       (clk),
                .reset     (rstN[g]),
                .start     (start[g]),
                .size      (size[g]),
                .byte_off  (byteOff[g]),
                .b_data    (bData[g]),
                .mem_rdata (memRdata[g]),
                .mem_rd    (memRd[g]),
                .busy      (busy[g]),
                .wc_data   (wcData[g]),
                .wc_valid  (wcValid[g]),
                .err       (err[g])
            );
        end
    endgenerate

    // Memory: read data is only meaningful exactly MEM_LAT cycles after mem_rd.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            rdPipe[i] <= {rdPipe[i][2:0], memRd[i]};
            junk[i]   <= $urandom;
        end
    end
    always_comb begin
        for (int i = 0; i < N; i++)
            memRdata[i] = rdPipe[i][latOf(i) - 1] ? memWord[i] : junk[i];
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] mergeModel(input logic [31:0] old, input logic [31:0] b,
                                               input logic [1:0] sz, input logic [1:0] off);
        int          sh;
        logic [31:0] mask;
        case (sz)
            2'b10: begin sh = 8 * int'(off);       mask = 32'h0000_00FF << sh; end
            2'b01: begin sh = off[1] ? 16 : 0;     mask = 32'h0000_FFFF << sh; end
            default: return b;
        endcase
        return (old & ~mask) | ((b << sh) & mask);
    endfunction

    function automatic bit misModel(input logic [1:0] sz, input logic [1:0] off);
        bit m;
        m = (sz == 2'b11) || (sz == 2'b01 && off[0]) || (sz == 2'b00 && off != 2'b00);
        return m && ALIGN_ON;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idleCycle(input int i);
        bit inBusy;
        inBusy     = cyc < nextFree[i];
        start[i]   = inBusy && (cyc == lastIssue[i] + 1 || $urandom_range(0, 2) == 0);
        size[i]    = 2'($urandom_range(0, 3));
        byteOff[i] = 2'($urandom_range(0, 3));
        bData[i]   = $urandom;
        @(negedge clk); #1;
    endtask

    task automatic issue(input int i, input logic [1:0] sz, input logic [1:0] off,
                         input logic [31:0] b, input logic [31:0] mem, input int unsigned gap);
        exp_t e;
        bit   mis;
        bit   sub;
        while (cyc < nextFree[i] + gap) idleCycle(i);
        mis        = misModel(sz, off);
        sub        = !mis && (sz == 2'b10 || sz == 2'b01);
        memWord[i] = mem;
        start[i]   = 1'b1;
        size[i]    = sz;
        byteOff[i] = off;
        bData[i]   = b;
        e.issued   = cyc;
        e.due      = cyc + (sub ? 32'(2 + latOf(i)) : 32'd1);
        e.isSub    = sub;
        e.isErr    = mis;
        e.data     = mis ? 32'h0 : mergeModel(mem, b, sz, off);
        exp_q[i].push_back(e);
        if (sub) rdQ[i].push_back(cyc + 1);
        lastIssue[i] = cyc;
        nextFree[i]  = e.due;
        @(negedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic randomRun(input int i, input int count);
        for (int k = 0; k < count; k++)
            issue(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom_range(0, 2));
    endtask

    task automatic run(input int i);
        case (i)
            0: begin
                issue(0, 2'b00, 2'b00, 32'hDEADBEEF, 32'h5555_AAAA, 2);
                issue(0, 2'b10, 2'b10, 32'h0000_00AB, 32'h1122_3344, 2);
                issue(0, 2'b10, 2'b00, 32'h0000_00AB, 32'h1122_3344, 2);
                issue(0, 2'b00, 2'b00, 32'h0102_0304, 32'h0, 0);
                if (ALIGN_ON) issue(0, 2'b01, 2'b01, 32'h0000_BEEF, 32'h1122_3344, 1);
                randomRun(0, 50);
            end
            1: begin
                issue(1, 2'b01, 2'b10, 32'h0000_CAFE, 32'h1122_3344, 2);
                issue(1, 2'b01, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 1);
                randomRun(1, 40);
            end
            default: begin
                randomRun(2, 20);
                issue(2, 2'b10, 2'b01, 32'h0000_0077, 32'hA5A5_A5A5, 1);
                idleCycle(2);
                idleCycle(2);
                // Now in the middle of WAIT; pull reset for one edge.
                rstN[2]  = 1'b0;
                start[2] = 1'b0;
                @(negedge clk); #1;
                rstN[2]     = 1'b1;
                nextFree[2] = cyc;
                randomRun(2, 20);
            end
        endcase
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] want);
        nVec++;
        if (act !== want) begin
            nBad++;
            $display("FAIL %s lat%0d cyc %0d: got %h expected %h", name, latOf(i), cyc, act, want);
        end
    endtask

    task automatic checkInst(input int i);
        exp_t e;
        bit   expRd;
        bit   expV;
        bit   expE;
        bit   expBusy;
        if (rstSeen[i]) begin
            exp_q[i].delete();
            rdQ[i].delete();
            expWc[i] = 32'h0;
        end
        expRd = rdQ[i].size() > 0 && rdQ[i][0] == cyc;
        if (expRd) void'(rdQ[i].pop_front());
        expV = 1'b0; expE = 1'b0; expBusy = 1'b0;
        if (exp_q[i].size() > 0) begin
            e       = exp_q[i][0];
            expBusy = e.isSub && cyc > e.issued && cyc < e.due;
            if (e.due == cyc) begin
                expV = !e.isErr;
                expE = e.isErr;
                if (!e.isErr) expWc[i] = e.data;
                void'(exp_q[i].pop_front());
            end
        end
        check("mem_rd",   i, 32'(memRd[i]),   32'(expRd));
        check("wc_valid", i, 32'(wcValid[i]), 32'(expV));
        check("err",      i, 32'(err[i]),     32'(expE));
        check("busy",     i, 32'(busy[i]),    32'(expBusy));
        check("wc_data",  i, wcData[i],       expWc[i]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < N; i++) rstSeen[i] = !rstN[i];
            @(negedge clk);
            for (int i = 0; i < N; i++) checkInst(i);
        end
    end

    // ---------------- main sequence / report ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            rstN[i]      = 1'b0;
            start[i]     = 1'b0;
            size[i]      = 2'b00;
            byteOff[i]   = 2'b00;
            bData[i]     = 32'h0;
            memWord[i]   = 32'h0;
            lastIssue[i] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            rstN[i]     = 1'b1;
            nextFree[i] = cyc;
        end
        fork
            run(0);
            run(1);
            run(2);
        join
        repeat (10) @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
